fpu_flag_collector: RTL and testbench
=====================================

// Module: fpu_flag_collector
// PURPOSE
//  Consumer side of the FPU exception interface. Takes per-operation flag pulses from the exception stage
//  (invalid/overflow/underflow/inexact), accumulates them into sticky status with saturating counters,
//  raises an interrupt when a trap-enabled flag is set, and serves a host read/clear via a 4-phase req/ack.
//  Sits between the FPU result pipeline and the core's status/CSR logic.
// PARAMETERS
//  COUNT_W   16   width of op_count and exc_count; both saturate at 2**COUNT_W-1
// PORTS
//  clk           in   1        clock, rising edge
//  rst           in   1        asynchronous reset, active-high
//  flag_valid    in   1        flag_* inputs valid this cycle (one FPU result retired)
//  invalid_in    in   1        invalid-operation flag of retiring result
//  overflow_in   in   1        overflow flag
//  underflow_in  in   1        underflow flag
//  inexact_in    in   1        inexact flag
//  trap_en       in   4        per-flag trap enable {invalid,overflow,underflow,inexact}
//  rd_req        in   1        host read request (4-phase)
//  rd_clr        in   1        sampled with rd_req rise: clear sticky flags and counters after snapshot
//  rd_ack        out  1        read acknowledge
//  rd_flags      out  4        snapshot of sticky {invalid,overflow,underflow,inexact}
//  rd_op_count   out  COUNT_W  snapshot of retired-op count
//  rd_exc_count  out  COUNT_W  snapshot of count of ops with any flag set
//  sticky        out  4        live sticky flags, same bit order
//  irq           out  1        level interrupt: |(sticky & trap_en)
// BEHAVIOUR
//  Reset: all registers/outputs 0; FSM in IDLE. Async assert, release synchronous to clk by the instantiator.
//  Accumulate (every cycle, any FSM state): if flag_valid: sticky <= sticky | flags; op_count += 1;
//   exc_count += 1 when |flags. Counters saturate, never wrap. Flag inputs ignored when flag_valid = 0.
//  Latency: flag_valid at edge N -> sticky/counters updated at N+1; irq updated at N+1 (computed from next
//   sticky and current trap_en). trap_en change alone -> irq follows one cycle later. irq is not sticky itself.
//  FSM states IDLE, ACK, DROP:
//   IDLE: on rd_req=1: snapshot next-state sticky/op_count/exc_count (includes a same-cycle flag_valid) into
//    rd_*; if rd_clr=1, sticky/op_count/exc_count <= 0 (same-cycle flag_valid already in snapshot, not
//    re-added); rd_ack <= 1; go ACK.
//   ACK: rd_ack=1, rd_* held stable. Stay while rd_req=1. On rd_req=0: rd_ack <= 0; go DROP.
//   DROP: one cycle, rd_ack=0; go IDLE. A new rd_req in DROP is not serviced until IDLE (req held by host).
//  rd_clr is sampled only in IDLE on the request cycle; ignored elsewhere.
//  Flags arriving in ACK/DROP accumulate normally and are visible on the next read; never lost.
//  rd_* outputs keep the last snapshot after handshake completes; 0 after reset.
//  Clear and saturation: a clear resets a saturated counter to 0; increments resume next valid op.
//  Reset mid-handshake: rd_ack drops immediately (async), FSM -> IDLE, snapshot and sticky cleared.
// TESTING
//  1 reset, no stimulus -> sticky=0, irq=0, rd_ack=0, all counts 0.
//  2 3 valid ops: {0,0,0,1},{0,0,0,0},{1,0,0,0}; read no clr -> rd_flags=4'b1001, rd_op_count=3,
//    rd_exc_count=2; sticky unchanged after read.
//  3 trap_en=4'b0100, one op with overflow_in=1 at edge N -> irq=1 from N+1; read with rd_clr=1 ->
//    sticky=0, irq=0 the cycle after the request edge.
//  4 rd_req with rd_clr=1 in same cycle as valid op inexact_in=1 -> rd_flags[0]=1, rd_op_count includes it;
//    post-clear sticky=0, op_count=0.
//  5 COUNT_W=4, 17 valid ops all with underflow_in -> op_count=exc_count=15 (saturated), then clear -> 0.
//  6 assert rst while in ACK -> rd_ack=0 same cycle, FSM IDLE, next rd_req serviced normally.

Source files
------------

// File: rtl/fpu_flag_collector_if.sv
// rtl/fpu_flag_collector_if.sv - FPU flag input and host read handshake bundle
interface fpu_flag_collector_if #(
  parameter int COUNT_W = 16
);
  logic               flag_valid;
  logic               invalid_in;
  logic               overflow_in;
  logic               underflow_in;
  logic               inexact_in;
  logic [3:0]         trap_en;
  logic               rd_req;
  logic               rd_clr;
  logic               rd_ack;
  logic [3:0]         rd_flags;
  logic [COUNT_W-1:0] rd_op_count;
  logic [COUNT_W-1:0] rd_exc_count;
  logic [3:0]         sticky;
  logic               irq;

  modport slave (
    input  flag_valid, invalid_in, overflow_in, underflow_in, inexact_in, trap_en,
    input  rd_req, rd_clr,
    output rd_ack, rd_flags, rd_op_count, rd_exc_count, sticky, irq
  );

  modport master (
    output flag_valid, invalid_in, overflow_in, underflow_in, inexact_in, trap_en,
    output rd_req, rd_clr,
    input  rd_ack, rd_flags, rd_op_count, rd_exc_count, sticky, irq
  );
endinterface

// File: rtl/fpu_flag_collector.sv
// rtl/fpu_flag_collector.sv - sticky FPU exception flags, saturating counters, irq and 4-phase host read
module fpu_flag_collector #(
  parameter int COUNT_W = 16
) (
  input logic                 clk,
  input logic                 rst,
  fpu_flag_collector_if.slave bus
);
  localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, ACK, DROP} state_t;

  state_t             state_q, state_d;
  logic               snap_en;
  logic               clr;
  logic [3:0]         flags;
  logic [3:0]         sticky_q, sticky_acc, sticky_d;
  logic [COUNT_W-1:0] op_q, op_acc;
  logic [COUNT_W-1:0] exc_q, exc_acc;
  logic               irq_q;
  logic [3:0]         snap_flags_q;
  logic [COUNT_W-1:0] snap_op_q, snap_exc_q;

  assign flags = {bus.invalid_in, bus.overflow_in, bus.underflow_in, bus.inexact_in};

  always_comb begin
    state_d = state_q;
    snap_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.rd_req) begin
          snap_en = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     if (!bus.rd_req) state_d = DROP;
      DROP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Accumulated values include this cycle's retiring op, so a read snapshot sees it too.
  always_comb begin
    sticky_acc = sticky_q;
    op_acc     = op_q;
    exc_acc    = exc_q;
    if (bus.flag_valid) begin
      sticky_acc = sticky_q | flags;
      if (op_q != CNT_MAX) op_acc = op_q + COUNT_W'(1);
      if ((|flags) && (exc_q != CNT_MAX)) exc_acc = exc_q + COUNT_W'(1);
    end
  end

  assign clr      = snap_en & bus.rd_clr;
  assign sticky_d = clr ? 4'b0000 : sticky_acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sticky_q     <= '0;
      op_q         <= '0;
      exc_q        <= '0;
      irq_q        <= 1'b0;
      snap_flags_q <= '0;
      snap_op_q    <= '0;
      snap_exc_q   <= '0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      op_q     <= clr ? '0 : op_acc;
      exc_q    <= clr ? '0 : exc_acc;
      irq_q    <= |(sticky_d & bus.trap_en);
      if (snap_en) begin
        snap_flags_q <= sticky_acc;
        snap_op_q    <= op_acc;
        snap_exc_q   <= exc_acc;
      end
    end
  end

  // Decoding ack from the state register lets an async reset drop it immediately.
  assign bus.rd_ack       = (state_q == ACK);
  assign bus.rd_flags     = snap_flags_q;
  assign bus.rd_op_count  = snap_op_q;
  assign bus.rd_exc_count = snap_exc_q;
  assign bus.sticky       = sticky_q;
  assign bus.irq          = irq_q;
endmodule

// File: tb/tb_fpu_flag_collector.sv
// tb/tb_fpu_flag_collector.sv - scoreboard bench for fpu_flag_collector
module tb_fpu_flag_collector;
  localparam int CW = 4;

  typedef struct packed {
    logic [3:0]    f;
    logic [CW-1:0] op;
    logic [CW-1:0] exc;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  rd_t  exp_q[$];
  rd_t  mon_e;
  logic ack_prev = 1'b0;

  always #5 clk = ~clk;

  fpu_flag_collector_if #(.COUNT_W(CW)) bus ();
  fpu_flag_collector #(.COUNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every rising rd_ack presents a snapshot that must match the oldest expected read.
  always @(negedge clk) begin
    if (!rst && bus.rd_ack && !ack_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_flags", int'(bus.rd_flags), int'(mon_e.f));
        chk("rd_op_count", int'(bus.rd_op_count), int'(mon_e.op));
        chk("rd_exc_count", int'(bus.rd_exc_count), int'(mon_e.exc));
      end
    end
    ack_prev = bus.rd_ack;
  end

  task automatic set_flags(input logic [3:0] f);
    {bus.invalid_in, bus.overflow_in, bus.underflow_in, bus.inexact_in} = f;
  endtask

  task automatic op(input logic [3:0] f);
    bus.flag_valid = 1'b1;
    set_flags(f);
    @(posedge clk); #1;
    bus.flag_valid = 1'b0;
    set_flags(4'b0000);
  endtask

  task automatic start_read(input logic clr, input logic v, input logic [3:0] f,
                            input logic [3:0] ef, input int eo, input int ee);
    rd_t e;
    e.f = ef;
    e.op = CW'(eo);
    e.exc = CW'(ee);
    exp_q.push_back(e);
    bus.rd_req = 1'b1;
    bus.rd_clr = clr;
    bus.flag_valid = v;
    set_flags(f);
    @(posedge clk); #1;
    bus.flag_valid = 1'b0;
    set_flags(4'b0000);
    bus.rd_clr = 1'b0;
    chk("ack_rise", int'(bus.rd_ack), 1);
  endtask

  task automatic finish_read();
    int n;
    n = 0;
    bus.rd_req = 1'b0;
    while (bus.rd_ack && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ack_fall", int'(bus.rd_ack), 0);
    @(posedge clk); #1;
  endtask

  task automatic read(input logic clr, input logic [3:0] ef, input int eo, input int ee);
    start_read(clr, 1'b0, 4'b0000, ef, eo, ee);
    finish_read();
  endtask

  initial begin
    rst = 1'b1;
    bus.flag_valid = 1'b0;
    set_flags(4'b0000);
    bus.trap_en = 4'b0000;
    bus.rd_req = 1'b0;
    bus.rd_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: reset state
    chk("reset_sticky", int'(bus.sticky), 0);
    chk("reset_irq", int'(bus.irq), 0);
    chk("reset_ack", int'(bus.rd_ack), 0);
    chk("reset_rd_op", int'(bus.rd_op_count), 0);
    chk("reset_rd_exc", int'(bus.rd_exc_count), 0);

    // flags without flag_valid are ignored
    set_flags(4'b1111);
    @(posedge clk); #1;
    set_flags(4'b0000);
    chk("ignored_flags", int'(bus.sticky), 0);

    // 2: three ops, read without clear
    op(4'b0001);
    op(4'b0000);
    op(4'b1000);
    read(1'b0, 4'b1001, 3, 2);
    chk("sticky_after_read", int'(bus.sticky), 4'b1001);
    read(1'b1, 4'b1001, 3, 2);
    chk("sticky_after_clr", int'(bus.sticky), 0);

    // 3: trap on overflow, cleared by read
    bus.trap_en = 4'b0100;
    @(posedge clk); #1;
    chk("irq_idle", int'(bus.irq), 0);
    op(4'b0100);
    chk("irq_set", int'(bus.irq), 1);
    start_read(1'b1, 1'b0, 4'b0000, 4'b0100, 1, 1);
    chk("clr_sticky", int'(bus.sticky), 0);
    chk("clr_irq", int'(bus.irq), 0);
    finish_read();
    op(4'b0001);
    chk("irq_untrapped", int'(bus.irq), 0);
    bus.trap_en = 4'b0001;
    chk("irq_trap_lag", int'(bus.irq), 0);
    @(posedge clk); #1;
    chk("irq_trap_follow", int'(bus.irq), 1);
    bus.trap_en = 4'b0000;
    @(posedge clk); #1;
    chk("irq_trap_off", int'(bus.irq), 0);
    read(1'b1, 4'b0001, 1, 1);

    // 4: clear read coinciding with a retiring op
    start_read(1'b1, 1'b1, 4'b0001, 4'b0001, 1, 1);
    chk("same_cycle_sticky", int'(bus.sticky), 0);
    finish_read();
    read(1'b0, 4'b0000, 0, 0);

    // 5: saturation, clear, resume, ops during ACK
    for (int i = 0; i < 17; i++) op(4'b0010);
    read(1'b1, 4'b0010, 15, 15);
    read(1'b0, 4'b0000, 0, 0);
    op(4'b0000);
    start_read(1'b0, 1'b0, 4'b0000, 4'b0000, 1, 0);
    op(4'b1000);
    chk("ack_held", int'(bus.rd_ack), 1);
    chk("snap_flags_stable", int'(bus.rd_flags), 0);
    chk("snap_op_stable", int'(bus.rd_op_count), 1);
    finish_read();
    read(1'b1, 4'b1000, 2, 1);

    // 6: reset during ACK
    op(4'b0100);
    start_read(1'b0, 1'b0, 4'b0000, 4'b0100, 1, 1);
    @(negedge clk); #1;
    rst = 1'b1;
    bus.rd_req = 1'b0;
    #1;
    chk("rst_ack", int'(bus.rd_ack), 0);
    chk("rst_sticky", int'(bus.sticky), 0);
    chk("rst_rd_flags", int'(bus.rd_flags), 0);
    chk("rst_rd_op", int'(bus.rd_op_count), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    op(4'b0001);
    read(1'b0, 4'b0001, 1, 1);

    chk("pending_reads", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
